ldpc_iter_ctrl: RTL and testbench

Iteration scheduler for the LDPC min-sum decoder core. It sequences the channel-LLR load, then alternating check-node (CNU) and variable-node (VNU) update phases. After each iteration it samples the parity-check syndrome and stops on early success or when the iteration budget runs out. It sits above the CNU/VNU arrays and the decoded-bit register, and drives only their enables and strobes.

---
 rtl/ldpc_pkg.sv | 24 ++
 rtl/ldpc_phase_timer.sv | 42 ++++
 rtl/ldpc_iter_ctrl.sv | 137 +++++++++++++
 tb/tb_ldpc_iter_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldpc_pkg: shared state encoding and default timing constants     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ldpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CNU   = 3'd2,
    ST_VNU   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int unsigned DEF_MAX_ITER  = 10;
  localparam int unsigned DEF_ITER_W    = 4;
  localparam int unsigned DEF_LOAD_CYC  = 2;
  localparam int unsigned DEF_PHASE_CYC = 4;
  localparam int unsigned DEF_CNT_W     = 3;

endpackage
`default_nettype wire

// File: rtl/ldpc_phase_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldpc_phase_timer: loadable saturating down-counter, zero flag    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ldpc_phase_timer
  import ldpc_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Holds at zero so idle states need no explicit control.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ldpc_iter_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldpc_iter_ctrl: LOAD / CNU / VNU / CHECK iteration scheduler     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int unsigned MAX_ITER  = DEF_MAX_ITER,
  parameter int unsigned ITER_W    = DEF_ITER_W,
  parameter int unsigned LOAD_CYC  = DEF_LOAD_CYC,
  parameter int unsigned PHASE_CYC = DEF_PHASE_CYC,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              syndrome_ok,
  output logic              busy,
  output logic              load_en,
  output logic              cnu_en,
  output logic              vnu_en,
  output logic              first_iter,
  output logic              hard_latch,
  output logic [ITER_W-1:0] iter_idx,
  output logic              done,
  output logic              success
);

  localparam logic [CNT_W-1:0]  C_LOAD_INIT  = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0]  C_PHASE_INIT = CNT_W'(PHASE_CYC - 1);
  localparam logic [ITER_W-1:0] C_LAST_ITER  = ITER_W'(MAX_ITER - 1);

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              success_q, success_d;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;

  ldpc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    success_d = success_q;
    tmr_load  = 1'b0;
    tmr_val   = C_PHASE_INIT;
    // Abort overrides everything, including the CHECK decision.
    if ((state_q != ST_IDLE) && abort) begin
      state_d   = ST_IDLE;
      success_d = 1'b0;
      tmr_load  = 1'b1;
      tmr_val   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_LOAD;
            iter_d    = '0;
            success_d = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = C_LOAD_INIT;
          end
        end
        ST_LOAD: begin
          if (tmr_zero) begin
            state_d  = ST_CNU;
            tmr_load = 1'b1;
          end
        end
        ST_CNU: begin
          if (tmr_zero) begin
            state_d  = ST_VNU;
            tmr_load = 1'b1;
          end
        end
        ST_VNU: begin
          if (tmr_zero) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (syndrome_ok) begin
            state_d   = ST_DONE;
            success_d = 1'b1;
          end else if (iter_q == C_LAST_ITER) begin
            state_d   = ST_DONE;
            success_d = 1'b0;
          end else begin
            state_d  = ST_CNU;
            iter_d   = iter_q + ITER_W'(1);
            tmr_load = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          iter_d  = iter_q + ITER_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      iter_q    <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      success_q <= success_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign load_en    = (state_q == ST_LOAD);
  assign cnu_en     = (state_q == ST_CNU);
  assign vnu_en     = (state_q == ST_VNU);
  assign first_iter = ((state_q == ST_CNU) || (state_q == ST_VNU)) && (iter_q == '0);
  assign hard_latch = (state_q == ST_VNU) && tmr_zero;
  assign done       = (state_q == ST_DONE);
  assign success    = success_q;
  assign iter_idx   = iter_q;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_iter_ctrl.sv
`default_nettype none
// Scoreboard bench for ldpc_iter_ctrl: directed decodes push per-cycle and
// per-done expectations; two monitors pop and compare on the falling edge.
module tb_ldpc_iter_ctrl;

  localparam int MAX_ITER  = 3;
  localparam int ITER_W    = 4;
  localparam int LOAD_CYC  = 2;
  localparam int PHASE_CYC = 4;
  localparam int CNT_W     = 3;
  localparam int ITER_CYC  = 2 * PHASE_CYC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic syndrome_ok = 1'b0;
  logic busy, load_en, cnu_en, vnu_en, first_iter, hard_latch, done, success;
  logic [ITER_W-1:0] iter_idx;

  typedef struct packed {
    logic busy, load, cnu, vnu, first, hl, done, succ;
    logic [ITER_W-1:0] iter;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } trace_t;

  typedef struct {
    logic              succ;
    logic [ITER_W-1:0] iter;
  } done_t;

  trace_t trace_q[$];
  done_t  done_q[$];
  int     errors = 0;
  int     checks = 0;
  obs_t   act;

  ldpc_iter_ctrl #(
    .MAX_ITER  (MAX_ITER),
    .ITER_W    (ITER_W),
    .LOAD_CYC  (LOAD_CYC),
    .PHASE_CYC (PHASE_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .syndrome_ok (syndrome_ok),
    .busy        (busy),
    .load_en     (load_en),
    .cnu_en      (cnu_en),
    .vnu_en      (vnu_en),
    .first_iter  (first_iter),
    .hard_latch  (hard_latch),
    .iter_idx    (iter_idx),
    .done        (done),
    .success     (success)
  );

  always #5 clk = ~clk;

  assign act = {busy, load_en, cnu_en, vnu_en, first_iter, hard_latch, done, success, iter_idx};

  // Expected outputs in cycle k of a decode that runs n_it iterations.
  function automatic obs_t model(int k, int n_it, logic succ, int abort_cyc);
    obs_t o;
    int   d, j, i, r;
    o = '0;
    d = LOAD_CYC + n_it * ITER_CYC + 1;
    if (abort_cyc > 0 && k > abort_cyc) begin
      o.iter = model(abort_cyc, n_it, succ, 0).iter;
      return o;
    end
    if (k > d) begin
      o.iter = ITER_W'(n_it);
      o.succ = succ;
    end else if (k == d) begin
      o.busy = 1'b1;
      o.done = 1'b1;
      o.succ = succ;
      o.iter = ITER_W'(n_it - 1);
    end else if (k <= LOAD_CYC) begin
      o.busy = 1'b1;
      o.load = 1'b1;
    end else begin
      j = k - LOAD_CYC - 1;
      i = j / ITER_CYC;
      r = j % ITER_CYC;
      o.busy  = 1'b1;
      o.iter  = ITER_W'(i);
      o.cnu   = (r < PHASE_CYC);
      o.vnu   = (r >= PHASE_CYC) && (r < 2 * PHASE_CYC);
      o.hl    = (r == 2 * PHASE_CYC - 1);
      o.first = (i == 0) && (r < 2 * PHASE_CYC);
    end
    return o;
  endfunction

  function automatic logic synd(int mode, int k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (k != LOAD_CYC + ITER_CYC);
      default: return 1'b0;
    endcase
  endfunction

  task automatic decode(input int ncyc, input int mode, input int n_it, input logic succ,
                        input int abort_cyc, input int s1, input int s2, input bit exp_done);
    @(negedge clk);
    start       = 1'b1;
    abort       = 1'b0;
    syndrome_ok = synd(mode, 0);
    @(posedge clk);
    if (exp_done) done_q.push_back('{succ, ITER_W'(n_it - 1)});
    for (int k = 1; k <= ncyc; k++) begin
      #1;
      trace_q.push_back('{k, model(k, n_it, succ, abort_cyc)});
      start       = (k == s1) || (k == s2);
      abort       = (k == abort_cyc);
      syndrome_ok = synd(mode, k);
      @(posedge clk);
    end
    #1;
    start       = 1'b0;
    abort       = 1'b0;
    syndrome_ok = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, act, obs_t'('0));
    end
  endtask

  always @(negedge clk) begin : mon_trace
    trace_t t;
    if (trace_q.size() > 0) begin
      t = trace_q.pop_front();
      checks++;
      if (act !== t.v) begin
        errors++;
        $display("FAIL trace cyc=%0d [busy ld cnu vnu first hl done succ iter] got=%b want=%b",
                 t.cyc, act, t.v);
      end
    end
  end

  always @(negedge clk) begin : mon_done
    done_t d;
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got=done_pulse want=no_pulse");
      end else begin
        d = done_q.pop_front();
        if ({success, iter_idx} !== {d.succ, d.iter}) begin
          errors++;
          $display("FAIL done_result got succ=%b iter=%0d want succ=%b iter=%0d",
                   success, iter_idx, d.succ, d.iter);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle_after_release");

    // Success in iteration 0.
    decode(14, 0, 1, 1'b1, 0, 0, 0, 1'b1);
    // Budget exhausted after MAX_ITER iterations.
    decode(32, 1, 3, 1'b0, 0, 0, 0, 1'b1);
    // Syndrome fails only at the first CHECK.
    decode(23, 2, 2, 1'b1, 0, 0, 0, 1'b1);
    // Start re-asserted in LOAD/CNU and DONE is ignored.
    decode(16, 0, 1, 1'b1, 0, 5, 12, 1'b1);
    // Abort during VNU, then a clean restart.
    decode(12, 0, 1, 1'b0, 8, 0, 0, 1'b0);
    decode(14, 0, 1, 1'b1, 0, 0, 0, 1'b1);

    // Asynchronous reset mid-CNU of iteration 1.
    decode(12, 1, 3, 1'b0, 0, 0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_mid_cnu");
    @(negedge clk);
    chk_zero("held_in_reset");
    rst_n = 1'b1;
    decode(14, 0, 1, 1'b1, 0, 0, 0, 1'b1);

    repeat (3) @(posedge clk);
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_missing got=%0d pending want=0", done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
